// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, feeder state type and window bit-offset helper.
package conv_pkg;
    localparam int BITWIDTH = 8;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int K        = 5;
    localparam int PAD      = (K - 1) / 2;

    typedef enum logic {LOAD, EMIT} feeder_state_t;

    function automatic int win_off(input int l, input int k, input int kk, input int bw);
        return (l * kk + k) * bw;
    endfunction
endpackage

// File: rtl/conv_window_select.sv
// conv_window_select: picks one zero-padded KxK window out of a flat frame.
module conv_window_select
    import conv_pkg::*;
#(
    parameter int BITWIDTH = conv_pkg::BITWIDTH,
    parameter int IMG_W    = conv_pkg::IMG_W,
    parameter int IMG_H    = conv_pkg::IMG_H,
    parameter int K        = conv_pkg::K,
    parameter int PAD      = conv_pkg::PAD,
    localparam int RW      = $clog2(IMG_H),
    localparam int CW      = $clog2(IMG_W)
) (
    input  logic [IMG_H*IMG_W*BITWIDTH-1:0] frame,
    input  logic [RW-1:0]                   row,
    input  logic [CW-1:0]                   col,
    output logic [K*K*BITWIDTH-1:0]         window
);
    for (genvar l = 0; l < K; l++) begin : g_row
        for (genvar k = 0; k < K; k++) begin : g_col
            localparam int DR = l - PAD;
            localparam int DC = k - PAD;
            int   rr, cc, idx;
            logic hit;
            assign rr  = int'(row) + DR;
            assign cc  = int'(col) + DC;
            assign hit = rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W;
            // Clamp the index so the unused side of the mux never reads outside the frame.
            assign idx = hit ? rr * IMG_W + cc : 0;
            assign window[win_off(l, k, K, BITWIDTH) +: BITWIDTH] =
                hit ? frame[idx * BITWIDTH +: BITWIDTH] : '0;
        end
    end
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: loads a raster image into a register frame, then
// streams one zero-padded KxK window per accepted cycle in raster order.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int BITWIDTH = conv_pkg::BITWIDTH,
    parameter int IMG_W    = conv_pkg::IMG_W,
    parameter int IMG_H    = conv_pkg::IMG_H,
    parameter int K        = conv_pkg::K,
    parameter int PAD      = (K - 1) / 2,
    localparam int RW      = $clog2(IMG_H),
    localparam int CW      = $clog2(IMG_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [BITWIDTH-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [K*K*BITWIDTH-1:0]    m_window,
    output logic [RW-1:0]              m_row,
    output logic [CW-1:0]              m_col,
    output logic                       m_last
);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

    feeder_state_t state_q, state_d;
    logic [RW-1:0] ld_row_q, ld_row_d, em_row_q, em_row_d;
    logic [CW-1:0] ld_col_q, ld_col_d, em_col_q, em_col_d;
    logic [IMG_H*IMG_W*BITWIDTH-1:0] frame_q;
    logic wr, adv;

    assign s_ready = state_q == LOAD && !rst;
    assign m_valid = state_q == EMIT;
    assign wr      = s_valid && s_ready;
    assign adv     = m_valid && m_ready;
    assign m_row   = em_row_q;
    assign m_col   = em_col_q;
    assign m_last  = m_valid && em_row_q == ROW_MAX && em_col_q == COL_MAX;

    always_comb begin
        state_d  = state_q;
        ld_row_d = ld_row_q;
        ld_col_d = ld_col_q;
        em_row_d = em_row_q;
        em_col_d = em_col_q;
        if (wr) begin
            ld_col_d = ld_col_q == COL_MAX ? '0 : ld_col_q + CW'(1);
            ld_row_d = ld_col_q != COL_MAX ? ld_row_q : ld_row_q == ROW_MAX ? '0 : ld_row_q + RW'(1);
            state_d  = ld_col_q == COL_MAX && ld_row_q == ROW_MAX ? EMIT : LOAD;
        end
        if (adv) begin
            em_col_d = em_col_q == COL_MAX ? '0 : em_col_q + CW'(1);
            em_row_d = em_col_q != COL_MAX ? em_row_q : em_row_q == ROW_MAX ? '0 : em_row_q + RW'(1);
            state_d  = m_last ? LOAD : EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            ld_row_q <= '0;
            ld_col_q <= '0;
            em_row_q <= '0;
            em_col_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_row_q <= ld_row_d;
            ld_col_q <= ld_col_d;
            em_row_q <= em_row_d;
            em_col_q <= em_col_d;
        end
    end

    // Frame is deliberately not reset; a new load overwrites every pixel.
    always_ff @(posedge clk) begin
        if (wr)
            frame_q[(int'(ld_row_q) * IMG_W + int'(ld_col_q)) * BITWIDTH +: BITWIDTH] <= s_data;
    end

    conv_window_select #(
        .BITWIDTH(BITWIDTH),
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .K       (K),
        .PAD     (PAD)
    ) u_select (
        .frame (frame_q),
        .row   (em_row_q),
        .col   (em_col_q),
        .window(m_window)
    );
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: randomized scenarios checked against a padded-image window model.
module tb_conv_window_feeder;
    localparam int W = 28, H = 28, KK = 5, P = 2, BW = 8, N = W * H, WW = KK * KK * BW;

    logic clk = 0, rst = 1, s_valid = 0, m_ready = 0;
    logic signed [BW-1:0] s_data = '0;
    logic s_ready, m_valid, m_last;
    logic [WW-1:0] m_window;
    logic [4:0] m_row, m_col;

    logic [BW-1:0] img [H][W];
    logic [WW-1:0] win_13, win_last;
    int checks = 0, passed = 0;

    conv_window_feeder dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window),
        .m_row(m_row), .m_col(m_col), .m_last(m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int l = 0; l < KK; l++)
            for (int k = 0; k < KK; k++) begin
                int rr = r + l - P, cc = c + k - P;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[(l*KK+k)*BW +: BW] = img[rr][cc];
            end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit gaps);
        bit bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                bit done = 0;
                s_data = img[r][c];
                while (!done) begin
                    s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    #1;
                    if (!s_ready) bad = 1;
                    done = s_valid;
                    step();
                end
            end
        s_valid = 0;
        checks++;
        if (bad) $display("FAIL load_ready: s_ready got 0 want 1 during load");
        else passed++;
    endtask

    task automatic run_emit(input int mode, input bit garbage, input int stop_at);
        int er = 0, ec = 0, n = 0, cyc = 0;
        bit rdy;
        while (n < stop_at && cyc < 4 * N) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            m_ready = rdy;
            s_valid = garbage;
            s_data  = 8'($urandom);
            #1;
            checks++;
            if (m_valid !== 1'b1) $display("FAIL emit_valid: got %b want 1 at (%0d,%0d)", m_valid, er, ec);
            else passed++;
            checks++;
            if (s_ready !== 1'b0) $display("FAIL emit_sready: got %b want 0", s_ready);
            else passed++;
            checks++;
            if ({m_row, m_col} !== {er[4:0], ec[4:0]})
                $display("FAIL emit_pos: got (%0d,%0d) want (%0d,%0d)", m_row, m_col, er, ec);
            else passed++;
            checks++;
            if (m_window !== model_win(er, ec))
                $display("FAIL emit_window (%0d,%0d): got %h want %h", er, ec, m_window, model_win(er, ec));
            else passed++;
            checks++;
            if (m_last !== (er == H - 1 && ec == W - 1))
                $display("FAIL emit_last (%0d,%0d): got %b", er, ec, m_last);
            else passed++;
            if (rdy) begin
                if (er == 13 && ec == 13) win_13 = m_window;
                if (er == H - 1 && ec == W - 1) win_last = m_window;
                n++;
                ec++;
                if (ec == W) begin
                    ec = 0;
                    er++;
                end
            end
            step();
            cyc++;
        end
        m_ready = 0;
        s_valid = 0;
        checks++;
        if (n != stop_at) $display("FAIL emit_count: got %0d want %0d", n, stop_at);
        else passed++;
        if (stop_at == N) begin
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1)
                $display("FAIL emit_done: got valid=%b ready=%b want valid=0 ready=1", m_valid, s_ready);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL reset_hold: got ready=%b valid=%b want 0/0", s_ready, m_valid);
        else passed++;
        rst = 0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_row, m_col, m_last} !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0})
            $display("FAIL reset_state: got ready=%b valid=%b row=%0d col=%0d last=%b", s_ready, m_valid, m_row, m_col, m_last);
        else passed++;
    endtask

    task automatic test_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'((r * 28 + c) % 100);
        load_frame(0);
        checks++;
        if (m_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", m_valid);
        else passed++;
        checks++;
        if (m_window[24*BW +: BW] !== 8'd58 || m_window[12*BW +: BW] !== 8'd0 || m_window[0 +: BW] !== 8'd0)
            $display("FAIL first_window: got e44=%0d e22=%0d e00=%0d want 58/0/0",
                     m_window[24*BW +: BW], m_window[12*BW +: BW], m_window[0 +: BW]);
        else passed++;
        run_emit(0, 0, N);
        checks++;
        if (win_13[0 +: BW] !== 8'd19 || win_13[24*BW +: BW] !== 8'd35)
            $display("FAIL window_13: got e00=%0d e44=%0d want 19/35", win_13[0 +: BW], win_13[24*BW +: BW]);
        else passed++;
    endtask

    task automatic test_negative();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'hFD;
        load_frame(0);
        run_emit(2, 0, N);
        checks++;
        if (win_last[0 +: BW] !== 8'hFD || win_last[12*BW +: BW] !== 8'hFD ||
            win_last[24*BW +: BW] !== 8'h00 || win_last[3*BW +: BW] !== 8'h00)
            $display("FAIL negative_last: got e00=%h e22=%h e44=%h e03=%h want fd/fd/00/00",
                     win_last[0 +: BW], win_last[12*BW +: BW], win_last[24*BW +: BW], win_last[3*BW +: BW]);
        else passed++;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
    endtask

    task automatic test_backpressure();
        fill_random();
        load_frame(1);
        run_emit(1, 0, N);
    endtask

    task automatic test_garbage();
        fill_random();
        load_frame(1);
        run_emit(2, 1, N);
    endtask

    task automatic test_reset_mid();
        fill_random();
        load_frame(0);
        run_emit(0, 0, 400);
        rst = 1;
        #1;
        checks++;
        if (s_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", s_ready);
        else passed++;
        step();
        checks++;
        if ({m_valid, s_ready, m_row, m_col} !== {1'b0, 1'b0, 5'd0, 5'd0})
            $display("FAIL mid_rst_state: got valid=%b ready=%b row=%0d col=%0d", m_valid, s_ready, m_row, m_col);
        else passed++;
        rst = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL mid_rst_release: got %b want 1", s_ready);
        else passed++;
        fill_random();
        load_frame(1);
        run_emit(2, 0, N);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_negative();
        test_backpressure();
        test_garbage();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Streaming producer for the first convolution layer.
- Accepts an unpadded IMG_H x IMG_W signed image as a raster pixel stream and stores it in a register frame.
- Then emits one K x K zero-padded ("same") window per cycle over a valid/ready interface. Window (r,c) equals rows r..r+K-1, cols c..c+K-1 of the image padded with PAD zeros on every side.
- Drives the convolution_point array sequentially instead of presenting a fully padded frame combinationally.

Parameters:
- BITWIDTH, 8, signed pixel width
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, window side
- PAD, 2, zero border per side; fixed at (K-1)/2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  input pixel valid
- s_ready  output  1  feeder can accept a pixel
- s_data  input  BITWIDTH  signed pixel, raster order (row-major, col fastest)
- m_valid  output  1  window valid
- m_ready  input  1  consumer accepts window
- m_window  output  K*K*BITWIDTH  packed window; element (l,k) at bits [((l*K+k)+1)*BITWIDTH-1 : (l*K+k)*BITWIDTH]
- m_row  output  $clog2(IMG_H)  output row index r of current window
- m_col  output  $clog2(IMG_W)  output column index c of current window
- m_last  output  1  high with the window at (IMG_H-1, IMG_W-1)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=LOAD; load and emit counters=0; m_valid=0.
  - s_ready=0 while rst is high.
  - m_row=0, m_col=0, m_last=0.
  - Frame registers are not cleared.
- LOAD state:
  - s_ready=1, m_valid=0.
  - Each s_valid&&s_ready cycle writes s_data into frame[ld_row][ld_col] and advances col, wrapping to row+1 at IMG_W-1.
  - When pixel (IMG_H-1, IMG_W-1) is accepted, the next state is EMIT and the emit counters are 0.
  - Gaps in s_valid are allowed.
- EMIT state:
  - s_ready=0, m_valid=1.
  - First window is valid the cycle after the last pixel handshake (latency 1).
  - On m_valid&&m_ready, advance (m_row,m_col) raster order: one window per cycle when m_ready is held high, IMG_H*IMG_W windows total.
- Backpressure: while m_valid&&!m_ready, m_window, m_row, m_col and m_last hold stable.
- Window contents:
  - element (l,k) = frame[r+l-PAD][c+k-PAD] if both indices are in range, else 0.
  - Pure selection; no arithmetic or width change. Signedness is preserved.
  - m_window may be combinational from the frame registers and registered counters, but must be glitch-stable relative to clk.
- m_last = (m_row==IMG_H-1)&&(m_col==IMG_W-1)&&m_valid.
- After the m_last handshake, the next cycle is LOAD with s_ready=1 and m_valid=0. There is no overlap between load and emit.
- s_valid during EMIT is ignored; no write occurs.
- Reset mid-LOAD or mid-EMIT aborts immediately. The next frame starts at pixel (0,0), and stale frame data is overwritten by the new load.
- Counter wrap: both counters use exact compare to IMG_W-1 / IMG_H-1; no power-of-two assumption.

Decomposition:
- Shared package conv_pkg holds:
  - default constants BITWIDTH, IMG_W, IMG_H, K, PAD
  - feeder_state_t enum {LOAD, EMIT}
  - a function returning the bit offset of window element (l,k)
- One combinational sub-module conv_window_select(frame, row, col, window). It contains the bounds check and zero-insert for all K*K taps, which keeps the FSM/counter logic separate.

Test Plan:
- Pixel p(r,c)=(r*28+c)%100, m_ready=1 -> after the 784th pixel:
  - m_valid next cycle.
  - Window(0,0): rows 0-1 and cols 0-1 zero; element(2,2)=0, element(4,4)=p(2,2)=58.
  - Exactly 784 windows with m_last only on (27,27).
- Same image, check window(13,13) -> element(l,k)=p(11+l,11+k), e.g. element(0,0)=p(11,11)=19.
- Negative pixels: all pixels=-3 (0xFD) -> window(27,27) has element(0..2,0..2)=0xFD and every element with l>2 or k>2 equal to 0.
- Toggle m_ready 1,0,0,1 during EMIT -> m_window/m_row/m_col unchanged on the low cycles; no window skipped or duplicated; total count 784.
- Random s_valid gaps during LOAD; s_valid=1 throughout EMIT with garbage data -> frame unaffected, window contents match the loaded image, s_ready=0 during EMIT.
- Assert rst at window 400 -> next cycle m_valid=0, s_ready=0; after release s_ready=1. A second full frame loads and emits from (0,0) with correct new data.
